// File: rtl/trena_rx_pkg.sv
// Shared definitions for the tape-measure frame receiver.
// Contents:
//   estado_t          4-bit FSM state encoding. The encoding is also the db_estado debug code.
//   ASCII_*           byte constants used by the frame parser.
//   eh_digito()       returns 1 when a 7-bit ASCII byte is '0'..'9'.
package trena_rx_pkg;

   typedef enum logic [3:0] {
      ESPERA_CENTENA = 4'h0,
      ESPERA_DEZENA  = 4'h1,
      ESPERA_UNIDADE = 4'h2,
      ESPERA_FINAL   = 4'h3,
      REGISTRA       = 4'h4,
      FIM            = 4'h5,
      ERRO_SINC      = 4'h6,
      DESCARTA       = 4'h7,
      ERRO           = 4'hE
   } estado_t;

   localparam logic [6:0] ASCII_ZERO  = 7'h30;
   localparam logic [6:0] ASCII_NOVE  = 7'h39;
   localparam logic [6:0] ASCII_FINAL = 7'h23;

   localparam logic [3:0] DB_INVALIDO = 4'hF;

   function automatic logic eh_digito(input logic [6:0] b);
      return (b >= ASCII_ZERO) && (b <= ASCII_NOVE);
   endfunction

endpackage

// File: rtl/contador_timeout_rx.sv
// Inter-byte timeout counter for the frame receiver.
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   synchronous, active-high
//   limpa     in   synchronous clear to zero (has priority over habilita)
//   habilita  in   count up by one per cycle
//   terminal  out  1 while the count equals LIMITE-1
// Counting stops at LIMITE-1 until the counter is cleared, so the count
// never wraps back to zero.
module contador_timeout_rx #(
   parameter int unsigned LIMITE  = 16,
   parameter int unsigned LARGURA = (LIMITE > 1) ? $clog2(LIMITE) : 1
) (
   input  logic clock,
   input  logic reset,
   input  logic limpa,
   input  logic habilita,
   output logic terminal
);

   logic [LARGURA-1:0] contagem;

   assign terminal = (contagem == LARGURA'(LIMITE - 1));

   always_ff @(posedge clock) begin
      if (reset || limpa) begin
         contagem <= '0;
      end else if (habilita && !terminal) begin
         contagem <= contagem + 1'b1;
      end
   end

endmodule

// File: rtl/receptor_medida_trena.sv
// Receive-side frame parser for the digital tape measure.
// A frame is the hundreds digit, the tens digit, the units digit, then '#'.
// The block outputs the last good frame as 3-digit BCD.
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high
//   dado_recebido  in   7-bit ASCII byte, valid while recebe_pronto=1
//   recebe_pronto  in   one-cycle byte strobe
//   medida         out  {centena, dezena, unidade} BCD of last good frame
//   pronto         out  one-cycle pulse when medida is updated
//   erro           out  one-cycle pulse on a malformed or abandoned frame
//   db_estado      out  current state code (4'hF for an illegal encoding)
// Build option: TRENA_RX_TIMEOUT_EN adds an inter-byte timeout of
// TIMEOUT_CICLOS cycles. Without this option, wait states wait indefinitely.
//
// state          | meaning
// ESPERA_CENTENA | idle, expecting hundreds digit
// ESPERA_DEZENA  | expecting tens digit
// ESPERA_UNIDADE | expecting units digit
// ESPERA_FINAL   | expecting '#'
// REGISTRA       | copy shadow digits into medida
// FIM            | pronto pulse
// ERRO_SINC      | erro pulse, stream already resynchronised by '#'
// ERRO           | erro pulse, then discard until '#'
// DESCARTA       | drop bytes until '#'
module receptor_medida_trena
   import trena_rx_pkg::*;
#(
   parameter int unsigned TIMEOUT_CICLOS = 50_000_000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [6:0]  dado_recebido,
   input  logic        recebe_pronto,
   output logic [11:0] medida,
   output logic        pronto,
   output logic        erro,
   output logic [3:0]  db_estado
);

   estado_t    estado;
   logic [3:0] centena, dezena, unidade;
   logic       tempo_esgotado;
   logic       eh_final;
   logic       eh_num;

   assign eh_final = (dado_recebido == ASCII_FINAL);
   assign eh_num   = eh_digito(dado_recebido);

`ifdef TRENA_RX_TIMEOUT_EN
   logic em_espera;
   logic terminal;

   // The timer runs only while a frame is partly received or being discarded.
   assign em_espera = (estado == ESPERA_DEZENA) || (estado == ESPERA_UNIDADE) ||
                      (estado == ESPERA_FINAL)  || (estado == DESCARTA);

   contador_timeout_rx #(
      .LIMITE (TIMEOUT_CICLOS)
   ) u_timeout (
      .clock    (clock),
      .reset    (reset),
      .limpa    (recebe_pronto || !em_espera),
      .habilita (em_espera),
      .terminal (terminal)
   );

   assign tempo_esgotado = terminal && em_espera;
`else
   // This build has no timer, so TIMEOUT_CICLOS has no effect here.
   // The expression is a constant 0 for any legal TIMEOUT_CICLOS.
   assign tempo_esgotado = 1'b0 & (TIMEOUT_CICLOS == 0);
`endif

   always_comb begin
      db_estado = DB_INVALIDO;
      case (estado)
         ESPERA_CENTENA, ESPERA_DEZENA, ESPERA_UNIDADE, ESPERA_FINAL,
         REGISTRA, FIM, ERRO_SINC, DESCARTA, ERRO: db_estado = estado;
         default:                                 db_estado = DB_INVALIDO;
      endcase
   end

   // pronto and erro are set on the edge that enters FIM / ERRO_SINC / ERRO.
   // As a result, each flag is high for exactly the cycle the FSM spends in that state.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado  <= ESPERA_CENTENA;
         centena <= '0;
         dezena  <= '0;
         unidade <= '0;
         medida  <= '0;
         pronto  <= 1'b0;
         erro    <= 1'b0;
      end else begin
         pronto <= 1'b0;
         erro   <= 1'b0;
         case (estado)
            ESPERA_CENTENA: begin
               if (recebe_pronto) begin
                  if (eh_num) begin
                     centena <= dado_recebido[3:0];
                     estado  <= ESPERA_DEZENA;
                  end else begin
                     estado <= eh_final ? ERRO_SINC : ERRO;
                     erro   <= 1'b1;
                  end
               end
            end
            ESPERA_DEZENA: begin
               if (recebe_pronto) begin
                  if (eh_num) begin
                     dezena <= dado_recebido[3:0];
                     estado <= ESPERA_UNIDADE;
                  end else begin
                     estado <= eh_final ? ERRO_SINC : ERRO;
                     erro   <= 1'b1;
                  end
               end else if (tempo_esgotado) begin
                  estado <= ERRO_SINC;
                  erro   <= 1'b1;
               end
            end
            ESPERA_UNIDADE: begin
               if (recebe_pronto) begin
                  if (eh_num) begin
                     unidade <= dado_recebido[3:0];
                     estado  <= ESPERA_FINAL;
                  end else begin
                     estado <= eh_final ? ERRO_SINC : ERRO;
                     erro   <= 1'b1;
                  end
               end else if (tempo_esgotado) begin
                  estado <= ERRO_SINC;
                  erro   <= 1'b1;
               end
            end
            ESPERA_FINAL: begin
               if (recebe_pronto) begin
                  if (eh_final) begin
                     estado <= REGISTRA;
                  end else begin
                     estado <= ERRO;
                     erro   <= 1'b1;
                  end
               end else if (tempo_esgotado) begin
                  estado <= ERRO_SINC;
                  erro   <= 1'b1;
               end
            end
            REGISTRA: begin
               medida <= {centena, dezena, unidade};
               pronto <= 1'b1;
               estado <= FIM;
            end
            FIM:       estado <= ESPERA_CENTENA;
            ERRO_SINC: estado <= ESPERA_CENTENA;
            ERRO:      estado <= DESCARTA;
            DESCARTA: begin
               if (recebe_pronto) begin
                  if (eh_final) begin
                     estado <= ESPERA_CENTENA;
                  end
               end else if (tempo_esgotado) begin
                  estado <= ERRO_SINC;
                  erro   <= 1'b1;
               end
            end
            default: estado <= ESPERA_CENTENA;
         endcase
      end
   end

endmodule

// File: tb/tb_receptor_medida_trena.sv
// Bench for receptor_medida_trena.
// It uses a table of hand-computed frame vectors and hand-written corner
// sequences for latency, reset, and the optional timeout.
// It also sends random byte streams, which are checked against a frame-level
// model of the protocol.
module tb_receptor_medida_trena;

   logic        clock = 1'b0;
   logic        reset;
   logic [6:0]  dado_recebido;
   logic        recebe_pronto;
   logic [11:0] medida;
   logic        pronto;
   logic        erro;
   logic [3:0]  db_estado;

   receptor_medida_trena #(
      .TIMEOUT_CICLOS (16)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .dado_recebido (dado_recebido),
      .recebe_pronto (recebe_pronto),
      .medida        (medida),
      .pronto        (pronto),
      .erro          (erro),
      .db_estado     (db_estado)
   );

   always #5 clock = ~clock;

   int checks    = 0;
   int failures  = 0;
   int n_pronto  = 0;
   int n_erro    = 0;
   int violacoes = 0;
   logic ant_pulso = 1'b0;

   // Pulse monitor, sampled on the falling edge.
   always @(negedge clock) begin
      if (pronto === 1'b1) n_pronto++;
      if (erro === 1'b1) n_erro++;
      if (pronto === 1'b1 && erro === 1'b1) violacoes++;
      if ((pronto === 1'b1 || erro === 1'b1) && ant_pulso) violacoes++;
      ant_pulso = (pronto === 1'b1 || erro === 1'b1);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [6:0]  b;
      logic [11:0] med;
      int          dp;
      int          de;
      logic [3:0]  st;
   } vec_t;

   vec_t tab[$];

   // Protocol model: the frame position plus a discard flag.
   int          m_pos  = 0;
   bit          m_disc = 0;
   logic [3:0]  m_dig [3];
   logic [11:0] m_med  = '0;

   function automatic bit is_dig(input logic [6:0] b);
      return (b >= 7'h30) && (b <= 7'h39);
   endfunction

   task automatic model_reset();
      m_pos = 0; m_disc = 0; m_med = '0;
      for (int k = 0; k < 3; k++) m_dig[k] = '0;
   endtask

   task automatic model_byte(input logic [6:0] b, output int dp, output int de);
      dp = 0; de = 0;
      if (m_disc) begin
         if (b == 7'h23) m_disc = 0;
      end else if (m_pos < 3) begin
         if (is_dig(b)) begin
            m_dig[m_pos] = b[3:0];
            m_pos++;
         end else begin
            de = 1;
            m_pos = 0;
            if (b != 7'h23) m_disc = 1;
         end
      end else begin
         if (b == 7'h23) begin
            m_med = {m_dig[0], m_dig[1], m_dig[2]};
            dp = 1;
         end else begin
            de = 1;
            m_disc = 1;
         end
         m_pos = 0;
      end
   endtask

   function automatic logic [3:0] model_estado();
      return m_disc ? 4'h7 : 4'(m_pos);
   endfunction

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic send(input logic [6:0] b, input int gap);
      dado_recebido = b;
      recebe_pronto = 1'b1;
      tick();
      recebe_pronto = 1'b0;
      dado_recebido = '0;
      repeat (gap) tick();
   endtask

   task automatic chk(input string nome, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", nome, act, req);
      end
   endtask

   // Send one byte, then check the DUT against the supplied expectations.
   task automatic byte_chk(input string nome, input logic [6:0] b, input int gap,
                           input logic [11:0] med, input int dp, input int de,
                           input logic [3:0] st);
      int p0, e0;
      p0 = n_pronto;
      e0 = n_erro;
      send(b, gap);
      chk({nome, "_medida"}, int'(medida), int'(med));
      chk({nome, "_pronto"}, n_pronto - p0, dp);
      chk({nome, "_erro"},   n_erro - e0, de);
      chk({nome, "_estado"}, int'(db_estado), int'(st));
   endtask

   task automatic byte_model(input string nome, input logic [6:0] b, input int gap);
      int dp, de;
      model_byte(b, dp, de);
      byte_chk(nome, b, gap, m_med, dp, de, model_estado());
   endtask

   initial begin
      int dp, de, p0, e0;
      logic [6:0] rb;

      reset = 1'b1;
      recebe_pronto = 1'b0;
      dado_recebido = '0;
      model_reset();
      repeat (3) tick();
      chk("rst_medida", int'(medida), 0);
      chk("rst_pronto", int'(pronto), 0);
      chk("rst_erro",   int'(erro), 0);
      chk("rst_estado", int'(db_estado), 0);
      reset = 1'b0;
      tick();

      // Exact latency of a good frame.
      send(7'h31, 8); send(7'h32, 8); send(7'h33, 8);
      dado_recebido = 7'h23;
      recebe_pronto = 1'b1;
      tick();
      recebe_pronto = 1'b0;
      chk("lat_n_estado", int'(db_estado), 4);
      chk("lat_n_pronto", int'(pronto), 0);
      chk("lat_n_medida", int'(medida), 0);
      tick();
      chk("lat_n1_pronto", int'(pronto), 1);
      chk("lat_n1_medida", int'(medida), 12'h123);
      chk("lat_n1_estado", int'(db_estado), 5);
      tick();
      chk("lat_n2_pronto", int'(pronto), 0);
      chk("lat_n2_estado", int'(db_estado), 0);
      chk("lat_n2_erro",   int'(erro), 0);
      repeat (4) tick();
      model_byte(7'h31, dp, de); model_byte(7'h32, dp, de);
      model_byte(7'h33, dp, de); model_byte(7'h23, dp, de);

      // Hand-computed frame vectors. medida starts at 12'h123.
      tab.push_back('{7'h34, 12'h123, 0, 0, 4'h1});
      tab.push_back('{7'h58, 12'h123, 0, 1, 4'h7});
      tab.push_back('{7'h35, 12'h123, 0, 0, 4'h7});
      tab.push_back('{7'h36, 12'h123, 0, 0, 4'h7});
      tab.push_back('{7'h23, 12'h123, 0, 0, 4'h0});
      tab.push_back('{7'h37, 12'h123, 0, 0, 4'h1});
      tab.push_back('{7'h38, 12'h123, 0, 0, 4'h2});
      tab.push_back('{7'h39, 12'h123, 0, 0, 4'h3});
      tab.push_back('{7'h23, 12'h789, 1, 0, 4'h0});
      tab.push_back('{7'h30, 12'h789, 0, 0, 4'h1});
      tab.push_back('{7'h23, 12'h789, 0, 1, 4'h0});
      tab.push_back('{7'h30, 12'h789, 0, 0, 4'h1});
      tab.push_back('{7'h30, 12'h789, 0, 0, 4'h2});
      tab.push_back('{7'h37, 12'h789, 0, 0, 4'h3});
      tab.push_back('{7'h23, 12'h007, 1, 0, 4'h0});
      tab.push_back('{7'h31, 12'h007, 0, 0, 4'h1});
      tab.push_back('{7'h61, 12'h007, 0, 1, 4'h7});
      tab.push_back('{7'h23, 12'h007, 0, 0, 4'h0});
      tab.push_back('{7'h31, 12'h007, 0, 0, 4'h1});
      tab.push_back('{7'h32, 12'h007, 0, 0, 4'h2});
      tab.push_back('{7'h33, 12'h007, 0, 0, 4'h3});
      tab.push_back('{7'h33, 12'h007, 0, 1, 4'h7});
      tab.push_back('{7'h23, 12'h007, 0, 0, 4'h0});
      tab.push_back('{7'h39, 12'h007, 0, 0, 4'h1});
      tab.push_back('{7'h39, 12'h007, 0, 0, 4'h2});
      tab.push_back('{7'h39, 12'h007, 0, 0, 4'h3});
      tab.push_back('{7'h23, 12'h999, 1, 0, 4'h0});
      tab.push_back('{7'h30, 12'h999, 0, 0, 4'h1});
      tab.push_back('{7'h30, 12'h999, 0, 0, 4'h2});
      tab.push_back('{7'h31, 12'h999, 0, 0, 4'h3});
      tab.push_back('{7'h23, 12'h001, 1, 0, 4'h0});
      foreach (tab[i]) begin
         model_byte(tab[i].b, dp, de);
         byte_chk("tab", tab[i].b, 8, tab[i].med, tab[i].dp, tab[i].de, tab[i].st);
      end

      // Reset in the middle of a frame. A strobe in the same cycle is overridden.
      send(7'h39, 8); send(7'h38, 8);
      reset = 1'b1;
      dado_recebido = 7'h35;
      recebe_pronto = 1'b1;
      tick();
      recebe_pronto = 1'b0;
      tick();
      chk("rstmid_medida", int'(medida), 0);
      chk("rstmid_pronto", int'(pronto), 0);
      chk("rstmid_erro",   int'(erro), 0);
      chk("rstmid_estado", int'(db_estado), 0);
      reset = 1'b0;
      model_reset();
      tick();
      byte_chk("rstmid_5a", 7'h35, 8, 12'h000, 0, 0, 4'h1);
      byte_chk("rstmid_5b", 7'h35, 8, 12'h000, 0, 0, 4'h2);
      byte_chk("rstmid_5c", 7'h35, 8, 12'h000, 0, 0, 4'h3);
      byte_chk("rstmid_fim", 7'h23, 8, 12'h555, 1, 0, 4'h0);
      model_byte(7'h35, dp, de); model_byte(7'h35, dp, de);
      model_byte(7'h35, dp, de); model_byte(7'h23, dp, de);

`ifdef TRENA_RX_TIMEOUT_EN
      // An abandoned frame times out after 16 idle cycles.
      p0 = n_pronto;
      e0 = n_erro;
      send(7'h31, 14);
      chk("to_antes_erro", n_erro - e0, 0);
      chk("to_antes_estado", int'(db_estado), 1);
      repeat (6) tick();
      chk("to_erro", n_erro - e0, 1);
      chk("to_pronto", n_pronto - p0, 0);
      chk("to_estado", int'(db_estado), 0);
      chk("to_medida", int'(medida), 12'h555);
      m_pos = 0;
      m_disc = 0;
      byte_chk("to_2", 7'h32, 6, 12'h555, 0, 0, 4'h1);
      byte_chk("to_3", 7'h33, 6, 12'h555, 0, 0, 4'h2);
      byte_chk("to_4", 7'h34, 6, 12'h555, 0, 0, 4'h3);
      byte_chk("to_fim", 7'h23, 6, 12'h234, 1, 0, 4'h0);
      model_byte(7'h32, dp, de); model_byte(7'h33, dp, de);
      model_byte(7'h34, dp, de); model_byte(7'h23, dp, de);
`endif

      // Random byte stream checked against the frame-level model.
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: rb = 7'(7'h30 + $urandom_range(0, 9));
            5, 6:          rb = 7'h23;
            default:       rb = 7'($urandom_range(0, 127));
         endcase
         byte_model("rnd", rb, $urandom_range(3, 6));
      end

      repeat (4) tick();
      chk("pulsos_isolados", violacoes, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/receptor_medida_trena.md
Name: receptor_medida_trena

Overview:
- Receive-side counterpart of the digital tape-measure transmit sequencer.
- Consumes ASCII bytes from the UART receiver, parsing frames of hundreds digit, tens digit, units digit and terminator '#' (7'h23).
- Presents the last valid measurement as 3-digit BCD, with a one-cycle pronto pulse per good frame and an erro pulse per malformed or abandoned frame.
- Sits between the serial RX data path and the display/host logic.

Parameters:
- TIMEOUT_CICLOS, 50_000_000, max clock cycles allowed between consecutive bytes of one frame; used only with TRENA_RX_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to reset state
- dado_recebido  in  7  ASCII byte from UART RX; valid only while recebe_pronto=1
- recebe_pronto  in  1  one-cycle strobe, one byte per pulse
- medida  out  12  BCD {centena[11:8], dezena[7:4], unidade[3:0]} of last valid frame
- pronto  out  1  one-cycle pulse when medida is updated
- erro  out  1  one-cycle pulse on frame error
- db_estado  out  4  current state code, debug

Behaviour:
- Reset (clock edge with reset=1): state espera_centena; medida=12'h000, pronto=0, erro=0, db_estado=4'h0. Shadow digit registers are cleared. Reset overrides any byte strobe in the same cycle and aborts any partial frame.
- Digit: 7'h30..7'h39; BCD value = dado_recebido[3:0]. Any other byte, including lowercase, is non-digit.
- States, db_estado code:
  - espera_centena(0): digit -> store centena, go espera_dezena.
  - espera_dezena(1): digit -> store dezena, go espera_unidade.
  - espera_unidade(2): digit -> store unidade, go espera_final.
  - espera_final(3): '#' -> registra.
  - registra(4): copy shadow digits to medida; -> fim.
  - fim(5): pronto=1; -> espera_centena.
  - erro_sinc(6): erro=1; -> espera_centena.
  - erro(E): erro=1; -> descarta.
  - descarta(7): wait for '#', then -> espera_centena; all other bytes are ignored silently.
- Bad byte in states 0-3:
  - byte == '#' -> erro_sinc, since the terminator already resynchronises the stream.
  - any other bad byte -> erro.
- Latency: terminator strobe sampled at edge N -> state registra after N. medida is updated and pronto=1 in the cycle after edge N+1; the next edge returns to espera_centena.
- medida is held unchanged between valid frames and is never altered by error frames.
- pronto and erro are Moore outputs, mutually exclusive, never high for 2 consecutive cycles.
- Strobes arriving while in registra, fim, erro_sinc or erro are dropped. UART byte spacing makes this unreachable in normal use.
- No strobe: all wait states hold.
- Unknown state encoding -> espera_centena, db_estado=4'hF for that cycle.

Optional Feature:
- Macro TRENA_RX_TIMEOUT_EN.
- Defined:
  - Counter clears on every accepted strobe and on entry to espera_centena.
  - Counter increments each cycle in espera_dezena, espera_unidade, espera_final and descarta.
  - Reaching TIMEOUT_CICLOS-1 with no strobe that cycle -> erro_sinc (erro pulse), then espera_centena.
  - A strobe on the terminal-count cycle takes priority over the timeout.
  - Counter width $clog2(TIMEOUT_CICLOS).
- Undefined: no counter is instantiated; wait states wait indefinitely.

Decomposition:
- Package trena_rx_pkg:
  - 4-bit state encodings listed above.
  - ASCII constants ASCII_ZERO=7'h30, ASCII_NOVE=7'h39, ASCII_FINAL=7'h23.
  - Function to test for a digit.
- One sub-module contador_timeout_rx: synchronous clear/enable counter with terminal-count flag, instantiated only under TRENA_RX_TIMEOUT_EN.
- FSM, shadow registers and output registers live in the top module.

Test Plan:
- Bytes '1','2','3','#', spaced 20 cycles -> medida=12'h123, pronto high exactly 1 cycle, 2 cycles after '#' strobe, erro never high.
- After 123 frame, send '4','X','5','6','#','7','8','9','#' -> erro pulse on 'X', bytes through first '#' discarded, then medida=12'h789 with one pronto; 12'h123 held in between.
- '0','#' -> erro pulse, state espera_centena (db_estado=0); then '0','0','7','#' -> medida=12'h007.
- Reset asserted after '9','8' of a frame, then '5','5','5','#' -> outputs zero after reset, final medida=12'h555, single pronto.
- With TRENA_RX_TIMEOUT_EN and TIMEOUT_CICLOS=16: '1' then silence 20 cycles -> erro pulse at 16th idle cycle. Then '2','3','4','#' -> medida=12'h234.
- Back-to-back frames '9','9','9','#','0','0','1','#', spaced 10 cycles -> two pronto pulses, medida 12'h999 then 12'h001.
